// File: rtl/mem_arbiter.sv
// Two-master Wishbone pipelined arbiter: instruction fetch (IF) and
// load-store (LS) share one slave port through a registered grant.
module mem_arbiter #(
   parameter bit FAIR = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic [31:0] if_adr_i,
   input  logic [31:0] if_dat_i,
   input  logic        if_we_i,
   input  logic [3:0]  if_sel_i,
   input  logic        if_stb_i,
   input  logic        if_cyc_i,
   output logic [31:0] if_dat_o,
   output logic        if_ack_o,
   output logic        if_stall_o,

   input  logic [31:0] ls_adr_i,
   input  logic [31:0] ls_dat_i,
   input  logic        ls_we_i,
   input  logic [3:0]  ls_sel_i,
   input  logic        ls_stb_i,
   input  logic        ls_cyc_i,
   output logic [31:0] ls_dat_o,
   output logic        ls_ack_o,
   output logic        ls_stall_o,

   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_stall_i
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT_IF,
      GRANT_LS
   } state_t;

   state_t state_q, state_d;
   logic   last_ls_q, last_ls_d;
   logic   gnt_if, gnt_ls;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         last_ls_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_ls_q <= last_ls_d;
      end
   end

   // LS wins a tie unless fairness hands the turn back to IF
   always_comb begin
      state_d   = state_q;
      last_ls_d = last_ls_q;
      unique case (state_q)
         IDLE: begin
            if (ls_cyc_i && (!if_cyc_i || !FAIR || !last_ls_q)) begin
               state_d   = GRANT_LS;
               last_ls_d = 1'b1;
            end else if (if_cyc_i) begin
               state_d   = GRANT_IF;
               last_ls_d = 1'b0;
            end
         end
         GRANT_IF: begin
            if (!if_cyc_i)
               state_d = IDLE;
         end
         GRANT_LS: begin
            if (!ls_cyc_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt_if = (state_q == GRANT_IF);
   assign gnt_ls = (state_q == GRANT_LS);

   // Master-side outputs depend only on the grant and slave inputs
   always_comb begin
      wb_adr_o   = '0;
      wb_dat_o   = '0;
      wb_we_o    = 1'b0;
      wb_sel_o   = '0;
      wb_stb_o   = 1'b0;
      wb_cyc_o   = 1'b0;
      if_dat_o   = '0;
      if_ack_o   = 1'b0;
      if_stall_o = 1'b1;
      ls_dat_o   = '0;
      ls_ack_o   = 1'b0;
      ls_stall_o = 1'b1;
      unique case (1'b1)
         gnt_if: begin
            wb_adr_o   = if_adr_i;
            wb_dat_o   = if_dat_i;
            wb_we_o    = if_we_i;
            wb_sel_o   = if_sel_i;
            wb_stb_o   = if_stb_i;
            wb_cyc_o   = if_cyc_i;
            if_dat_o   = wb_dat_i;
            if_ack_o   = wb_ack_i;
            if_stall_o = wb_stall_i;
         end
         gnt_ls: begin
            wb_adr_o   = ls_adr_i;
            wb_dat_o   = ls_dat_i;
            wb_we_o    = ls_we_i;
            wb_sel_o   = ls_sel_i;
            wb_stb_o   = ls_stb_i;
            wb_cyc_o   = ls_cyc_i;
            ls_dat_o   = wb_dat_i;
            ls_ack_o   = wb_ack_i;
            ls_stall_o = wb_stall_i;
         end
         default: ;
      endcase
   end

endmodule
